mac_pipe_param: RTL and testbench
=================================

Name: mac_pipe_param

Overview:
- Parametrised, pipelined multiply-accumulate unit; next generation of the team's fixed 8-bit MAC.
- Computes acc <= acc + a*b + cin, with a configurable operand width and accumulator width.
- Adds a valid handshake, a start-of-accumulation clear, a signed/unsigned mode, and wrap or saturate overflow handling.
- Sits in the datapath between operand sources and downstream filter/dot-product logic.

Parameters:
- WIDTH, 8: operand width of a and b.
- ACC_W, 20: accumulator width; must be >= 2*WIDTH.
- SIGNED, 0: 0 = unsigned operands and accumulator; 1 = two's-complement operands and accumulator.
- SAT, 0: 0 = wrap on overflow; 1 = clamp to the representable max/min.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample qualifier; a, b, cin and clr are sampled only when in_valid=1.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- cin  in  1  +1 added into this sample's accumulate.
- clr  in  1  start a new accumulation: this sample replaces the accumulator instead of adding to it.
- acc_out  out  ACC_W  accumulator value, registered.
- out_valid  out  1  one-cycle pulse; acc_out has just been updated.
- cout  out  1  overflow/carry from the latest accumulate; valid with out_valid.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (rst=0, asynchronous): all pipeline registers, acc_out, out_valid, cout and ovf go to 0 immediately.
  - Any in-flight sample is discarded; no out_valid is produced for it after rst releases.
- Stage 1 (edge after in_valid=1):
  - p_q <= a*b as a full 2*WIDTH product, signed if SIGNED=1.
  - Register cin_q, clr_q and v1 <= 1. If in_valid=0, v1 <= 0.
- Stage 2 (edge when v1=1):
  - base = clr_q ? 0 : acc_out.
  - sum = base + ext(p_q) + cin_q, computed at ACC_W+1 bits. ext is zero-extension when SIGNED=0, sign-extension when SIGNED=1.
  - acc_out <= result; out_valid <= 1 for exactly one cycle; cout <= overflow of this accumulate.
- Stage 2 when v1=0: acc_out, cout and ovf hold; out_valid <= 0.
- Latency: sample accepted at edge N -> acc_out updated and out_valid=1 after edge N+2. Throughput is one sample per cycle, with back-to-back accumulation through the stage-2 feedback. There is no backpressure.
- Overflow, unsigned: the carry out of bit ACC_W-1.
- Overflow, signed: base and ext(p_q) have the same sign and the result sign differs. cin is folded in at the same adder, and overflow is checked on the final ACC_W+1-bit sum.
- Result with SAT=0: the low ACC_W bits (wrap).
- Result with SAT=1 on overflow:
  - unsigned: all ones;
  - signed: 0111..1 for positive overflow, 1000..0 for negative overflow.
- ovf:
  - set on any overflowing accumulate;
  - on a clr accumulate, ovf <= overflow of that accumulate (the clr clears the history);
  - otherwise holds.
- Bubbles (in_valid=0 between samples) do not disturb acc_out.
- clr with in_valid=0 is ignored.
- cout is only meaningful while out_valid=1; it holds otherwise.

Test Plan:
1. Defaults; rst=0 for 2 cycles, release; samples 3*2 (clr=1), 5*1, 2*3, 3*3 with cin=1, back-to-back.
   -> out_valid pulses with acc_out = 6, 11, 17, 27; first pulse 2 cycles after the first sample; cout=0, ovf=0.
2. WIDTH=8, ACC_W=16, SAT=0: 255*255 (clr=1), then 22*12, then 255*255.
   -> 65025, 65289, then 64778 with cout=1 and ovf=1.
   -> A following clr sample 1*1 gives acc_out=1, ovf=0.
3. Same sequence as scenario 2 with SAT=1.
   -> third result = 65535, cout=1, ovf=1. Next sample 0*0 keeps acc_out=65535, cout=0, ovf=1.
4. SIGNED=1, WIDTH=8, ACC_W=16: -128*-128 (clr=1), then -128*-128.
   -> 16384, then 32767 (SAT=1) or -32768 (SAT=0), with cout=1 and ovf=1.
   -> Also check 3*(-2) from clr gives -6.
5. Bubbles: samples 4*4 (clr=1), idle 3 cycles, 2*2.
   -> acc_out holds 16 through the idle cycles; out_valid only on the 2 update cycles; final value 20.
6. Reset mid-pipeline: accumulate to 27, issue 7*7, assert rst one cycle later (while v1=1).
   -> outputs 0 immediately; after release, no out_valid until new samples are sent.
   -> First new sample 1*1 without clr gives 1.

Source files
------------

// File: rtl/mac_pipe_param.sv
// rtl/mac_pipe_param.sv - parametrised two-stage pipelined multiply-accumulate
module mac_pipe_param #(
    parameter int WIDTH  = 8,
    parameter int ACC_W  = 20,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clr,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    output logic             cout,
    output logic             ovf
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] p_q;
    logic               cin_q;
    logic               clr_q;
    logic               v1;

    logic [ACC_W-1:0]   base;
    logic [ACC_W:0]     base_x;
    logic [ACC_W:0]     p_x;
    logic [ACC_W:0]     sum;
    logic               ovf_now;
    logic [ACC_W-1:0]   result;

    // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext = (2*WIDTH)'($signed(a));
            b_ext = (2*WIDTH)'($signed(b));
        end else begin
            a_ext = (2*WIDTH)'(a);
            b_ext = (2*WIDTH)'(b);
        end
        prod = a_ext * b_ext;
    end

    always_comb begin
        base = clr_q ? '0 : acc_out;
        if (SIGNED != 0) begin
            base_x = (ACC_W+1)'($signed(base));
            p_x    = (ACC_W+1)'($signed(p_q));
        end else begin
            base_x = (ACC_W+1)'(base);
            p_x    = (ACC_W+1)'(p_q);
        end
        sum = base_x + p_x + {{ACC_W{1'b0}}, cin_q};

        // Signed: the extra bit disagrees with the result sign only on overflow; its value gives the true sign.
        if (SIGNED != 0) begin
            ovf_now = sum[ACC_W] ^ sum[ACC_W-1];
        end else begin
            ovf_now = sum[ACC_W];
        end

        result = sum[ACC_W-1:0];
        if ((SAT != 0) && ovf_now) begin
            if (SIGNED != 0) begin
                result = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                result = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q       <= '0;
            cin_q     <= 1'b0;
            clr_q     <= 1'b0;
            v1        <= 1'b0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                p_q   <= prod;
                cin_q <= cin;
                clr_q <= clr;
            end

            out_valid <= v1;
            if (v1) begin
                acc_out <= result;
                cout    <= ovf_now;
                ovf     <= clr_q ? ovf_now : (ovf | ovf_now);
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe_param.sv
// tb/tb_mac_pipe_param.sv - self-checking bench for mac_pipe_param across five parameter sets
module tb_mac_pipe_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  vld;
    logic [4:0]  cin;
    logic [4:0]  clr;
    logic [7:0]  a [5];
    logic [7:0]  b [5];
    logic [19:0] acc0;
    logic [15:0] acc1, acc2, acc3, acc4;
    logic [4:0]  ov;
    logic [4:0]  co;
    logic [4:0]  of;

    // 0: defaults, 1: 16-bit wrap, 2: 16-bit sat, 3: signed sat, 4: signed wrap
    mac_pipe_param u0 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .a(a[0]), .b(b[0]), .cin(cin[0]), .clr(clr[0]),
        .acc_out(acc0), .out_valid(ov[0]), .cout(co[0]), .ovf(of[0]));
    mac_pipe_param #(.WIDTH(8), .ACC_W(16), .SIGNED(0), .SAT(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .a(a[1]), .b(b[1]), .cin(cin[1]), .clr(clr[1]),
        .acc_out(acc1), .out_valid(ov[1]), .cout(co[1]), .ovf(of[1]));
    mac_pipe_param #(.WIDTH(8), .ACC_W(16), .SIGNED(0), .SAT(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .a(a[2]), .b(b[2]), .cin(cin[2]), .clr(clr[2]),
        .acc_out(acc2), .out_valid(ov[2]), .cout(co[2]), .ovf(of[2]));
    mac_pipe_param #(.WIDTH(8), .ACC_W(16), .SIGNED(1), .SAT(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(vld[3]), .a(a[3]), .b(b[3]), .cin(cin[3]), .clr(clr[3]),
        .acc_out(acc3), .out_valid(ov[3]), .cout(co[3]), .ovf(of[3]));
    mac_pipe_param #(.WIDTH(8), .ACC_W(16), .SIGNED(1), .SAT(0)) u4 (
        .clk(clk), .rst(rst), .in_valid(vld[4]), .a(a[4]), .b(b[4]), .cin(cin[4]), .clr(clr[4]),
        .acc_out(acc4), .out_valid(ov[4]), .cout(co[4]), .ovf(of[4]));

    typedef struct {
        int          dut;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic        clr;
        logic [19:0] acc;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        int          dut;
        logic [19:0] acc;
        logic        cout;
        logic        ovf;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    function automatic logic [19:0] acc_of(int k);
        case (k)
            0:       return acc0;
            1:       return {4'b0, acc1};
            2:       return {4'b0, acc2};
            3:       return {4'b0, acc3};
            default: return {4'b0, acc4};
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (rst && ov[k]) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out_valid: dut %0d pulsed with acc %0d, expected no pulse", k, acc_of(k));
                end else begin
                    e = sbq.pop_front();
                    check("sb_dut", k, e.dut);
                    check("sb_acc", acc_of(k), e.acc);
                    check("sb_cout", co[k], e.cout);
                    check("sb_ovf", of[k], e.ovf);
                end
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        #1;
        vld = '0;
        clr = '0;
        cin = '0;
    endtask

    task automatic drive(vec_t v);
        @(negedge clk);
        #1;
        vld = '0;
        clr = '0;
        cin = '0;
        a[v.dut]   = v.a;
        b[v.dut]   = v.b;
        cin[v.dut] = v.cin;
        clr[v.dut] = v.clr;
        vld[v.dut] = 1'b1;
        sbq.push_back('{v.dut, v.acc, v.cout, v.ovf});
    endtask

    function automatic vec_t mk(int d, int av, int bv, bit c, bit cl, int acc, bit cy, bit ov_f);
        vec_t v;
        v.dut = d; v.a = 8'(av); v.b = 8'(bv); v.cin = c; v.clr = cl;
        v.acc = 20'(acc); v.cout = cy; v.ovf = ov_f;
        return v;
    endfunction

    initial begin
        rst = 1'b0;
        vld = '0;
        cin = '0;
        clr = '0;
        for (int k = 0; k < 5; k++) begin
            a[k] = '0;
            b[k] = '0;
        end

        tbl.push_back(mk(0, 3,   2,   0, 1, 6,      0, 0));
        tbl.push_back(mk(0, 5,   1,   0, 0, 11,     0, 0));
        tbl.push_back(mk(0, 2,   3,   0, 0, 17,     0, 0));
        tbl.push_back(mk(0, 3,   3,   1, 0, 27,     0, 0));
        tbl.push_back(mk(1, 255, 255, 0, 1, 65025,  0, 0));
        tbl.push_back(mk(1, 22,  12,  0, 0, 65289,  0, 0));
        tbl.push_back(mk(1, 255, 255, 0, 0, 64778,  1, 1));
        tbl.push_back(mk(1, 1,   1,   0, 1, 1,      0, 0));
        tbl.push_back(mk(2, 255, 255, 0, 1, 65025,  0, 0));
        tbl.push_back(mk(2, 22,  12,  0, 0, 65289,  0, 0));
        tbl.push_back(mk(2, 255, 255, 0, 0, 65535,  1, 1));
        tbl.push_back(mk(2, 0,   0,   0, 0, 65535,  0, 1));
        tbl.push_back(mk(3, 128, 128, 0, 1, 16384,  0, 0));
        tbl.push_back(mk(3, 128, 128, 0, 0, 32767,  1, 1));
        tbl.push_back(mk(3, 3,   254, 0, 1, 65530,  0, 0));
        tbl.push_back(mk(4, 128, 128, 0, 1, 16384,  0, 0));
        tbl.push_back(mk(4, 128, 128, 0, 0, 32768,  1, 1));
        tbl.push_back(mk(4, 3,   254, 0, 1, 65530,  0, 0));

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            check("rst_acc", acc_of(k), 0);
            check("rst_out_valid", ov[k], 0);
            check("rst_cout", co[k], 0);
            check("rst_ovf", of[k], 0);
        end
        rst = 1'b1;

        // Table vectors, back-to-back
        for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);
        repeat (4) idle();

        // Bubbles: acc_out holds, and a clr without in_valid is ignored
        drive(mk(0, 4, 4, 0, 1, 16, 0, 0));
        idle();
        idle();
        check("bubble_hold_acc", acc0, 16);
        @(negedge clk);
        #1;
        vld = '0;
        clr[0] = 1'b1;
        check("bubble_hold_acc2", acc0, 16);
        check("bubble_no_pulse", ov[0], 0);
        idle();
        check("bubble_hold_acc3", acc0, 16);
        drive(mk(0, 2, 2, 0, 0, 20, 0, 0));
        repeat (3) idle();
        check("bubble_final", acc0, 20);

        // Reset with a sample in flight
        for (int i = 0; i < 4; i++) drive(tbl[i]);
        @(negedge clk);
        #1;
        a[0] = 8'd7;
        b[0] = 8'd7;
        vld[0] = 1'b1;
        @(negedge clk);
        #1;
        vld = '0;
        rst = 1'b0;
        #1;
        check("midrst_acc", acc0, 0);
        check("midrst_out_valid", ov[0], 0);
        check("midrst_ovf", of[0], 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (3) begin
            idle();
            check("post_rst_no_pulse", ov[0], 0);
        end
        check("post_rst_acc", acc0, 0);

        // Latency: out_valid after the second edge, accumulating onto the reset value
        drive(mk(0, 1, 1, 0, 0, 1, 0, 0));
        idle();
        check("latency_edge1", ov[0], 0);
        idle();
        check("latency_edge2", ov[0], 1);
        check("latency_acc", acc0, 1);
        repeat (3) idle();

        check("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
